// File: rtl/clk_div_gen.sv
// Programmable divided-clock / tick generator with fixed /2 and /4 outputs.
// Optional macro CLK_DIV_GATE_EN adds a run input that pauses the /N counter.
module clk_div_gen #(
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef CLK_DIV_GATE_EN
   input  logic             run,
`endif
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   output logic [DIV_W-1:0] div_cur,
   output logic             clk_div,
   output logic             tick,
   output logic             div2,
   output logic             div4
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF = DIV_W'(DIV_DEFAULT);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] cnt, n, pend;
   logic [DIV_W-1:0] cnt_nxt, n_nxt;
   logic [DIV_W:0]   half_nxt;
   logic             run_en, wrap, load, accept;

`ifdef CLK_DIV_GATE_EN
   assign run_en = run;
`else
   assign run_en = 1'b1;
`endif

   // A reload is keyed on the counter reaching N-1 rather than on the tick
   // register, so a boundary held across run=0 still applies the new divisor.
   assign wrap   = (cnt == n - ONE);
   assign accept = (state == IDLE) && div_valid;
   assign load   = (state == PENDING) && wrap && run_en;

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_valid) state_nxt = PENDING;
         PENDING: if (load)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      div_ready = (state == IDLE);
   end

   // Next counter/divisor values; outputs are registered from these so they
   // stay coherent with cnt in the same cycle.
   always_comb begin
      n_nxt = load ? pend : n;
      if (!run_en)   cnt_nxt = cnt;
      else if (wrap) cnt_nxt = '0;
      else           cnt_nxt = cnt + ONE;
      half_nxt = ({1'b0, n_nxt} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         n       <= DEF;
         pend    <= '0;
         clk_div <= 1'b0;
         tick    <= 1'b0;
         div2    <= 1'b0;
         div4    <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         n   <= n_nxt;
         if (accept) pend <= (div_in < TWO) ? TWO : div_in;
         if (run_en) clk_div <= ({1'b0, cnt_nxt} < half_nxt);
         tick <= run_en && (cnt_nxt == n_nxt - ONE);
         div2 <= ~div2;
         div4 <= div4 ^ div2;
      end
   end

   assign div_cur = n;

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Programmable clock-enable and divided-clock generator driven by the 100 MHz system clock.
- Produces fixed /2 and /4 square waves (50 MHz and 25 MHz at a 10 ns clk).
- Produces a programmable /N square wave plus a one-cycle tick strobe.
- Sits directly downstream of the top-level clock/reset source and feeds slower-rate logic.
- Divisor changes use a valid/ready handshake and take effect only at a period boundary, so clk_div never produces a runt pulse.

Parameters:
DIV_W, 8, width of the divisor field and of the internal counter.
DIV_DEFAULT, 4, divisor loaded at reset; must be in the range 2..2^DIV_W-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
div_in  in  DIV_W  requested divisor N.
div_valid  in  1  div_in is valid.
div_ready  out  1  block can accept a new divisor.
div_cur  out  DIV_W  divisor currently in effect.
clk_div  out  1  divided square wave, period N clk cycles.
tick  out  1  one-cycle strobe in the last cycle of each clk_div period.
div2  out  1  clk/2 square wave.
div4  out  1  clk/4 square wave.

Behaviour:
- Single clock; reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset values:
  - cnt=0, N=DIV_DEFAULT, div_cur=DIV_DEFAULT.
  - clk_div=0, tick=0, div2=0, div4=0.
  - div_ready=1, pending register cleared.
- Counter:
  - cnt runs 0..N-1 and wraps to 0.
  - It advances every cycle while rst=0.
  - The first cycle after reset release has cnt=1.
- Output timing:
  - clk_div and tick are registers updated from the next value of cnt, so they are coherent with cnt in the same cycle.
  - H = (N+1)>>1.
  - clk_div=1 when cnt<H, else 0. Duty is 50% for even N; odd N is high one cycle longer.
  - tick=1 exactly when cnt==N-1.
- Fixed dividers:
  - div2 toggles every cycle.
  - div4 toggles when div2 goes 1->0.
  - Both are free-running and independent of N and of the handshake.
- Handshake FSM:
  - IDLE: div_ready=1. When div_valid=1, div_in is captured into the pending register and the FSM moves to PENDING.
  - PENDING: div_ready=0, div_valid ignored. The cycle after the next tick:
    - N and div_cur take the pending value;
    - cnt restarts at 0 with the new N;
    - the FSM returns to IDLE, with div_ready=1 in that cycle.
- Clamp: captured values 0 or 1 are replaced by 2; div_cur reports the clamped value.
- Simultaneous events:
  - Accept in the same cycle as a tick: not applied at that tick; applied at the following boundary.
  - div_valid held high across a reload: the next value is accepted in the first IDLE cycle.
- Reset mid-operation:
  - Any pending divisor is discarded.
  - N returns to DIV_DEFAULT.
  - All outputs return to their reset values in the cycle rst is sampled high.
- Width: N=2^DIV_W-1 is legal; cnt never exceeds N-1 and no overflow is possible.

Optional Feature:
Macro CLK_DIV_GATE_EN.
- Defined:
  - Adds input port run (1 bit), placed after rst.
  - run=0: cnt and clk_div hold their values, tick is forced 0, and a pending reload does not apply.
  - run=1: normal operation resumes from the held cnt.
  - div2, div4 and the accept side of the handshake are unaffected by run.
- Not defined: no run port; the counter always runs.

Test Plan:
- Reset 2 cycles, then free run with N=4 -> clk_div pattern 1,0,0,1 repeating from the first post-reset cycle (cnt=1,2,3,0). tick high on cnt=3 every 4th cycle. div2 period 20 ns, div4 period 40 ns. div_cur=4.
- While cnt=1, drive div_valid=1, div_in=5 for one cycle -> div_ready=0 until the cycle after the next tick. Then div_cur=5, cnt=0, and clk_div shows 3 high / 2 low with tick every 5 cycles. No clk_div pulse shorter than 2 cycles during the switch.
- Load div_in=1, then div_in=0 -> each is accepted, and div_cur reads 2 after its boundary. clk_div then toggles every cycle and tick is high every 2nd cycle.
- Hold div_valid=1 with div_in=6, then div_in=3 on the cycle after acceptance -> 6 is applied at boundary 1. 3 is accepted in the first IDLE cycle and applied at the following boundary. No value is lost or double-applied.
- Accept div_in=10, then assert rst for 1 cycle before the boundary -> after reset div_cur=4, div_ready=1, and the 4-cycle pattern resumes; 10 is never applied.
- With CLK_DIV_GATE_EN defined, N=4: drop run for 3 cycles when cnt=2 -> cnt stays at 2 and clk_div stays 0 with no tick, while div2 and div4 keep toggling. After run=1, cnt continues 3,0,1 and tick fires at cnt=3.
